fetch_prefetch_queue: RTL

//   Parametrised instruction fetch front end for the next-generation CPU core. It replaces the

---
 rtl/fetch_prefetch_queue_pkg.sv | 45 ++++
 rtl/fetchq_store.sv | 31 +++
 rtl/fetch_prefetch_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_prefetch_queue_pkg
// Brief  : Bus/MMU encodings and queue entry layout shared by the fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } memAccess_t;

    typedef enum logic [1:0] {
        MEM_LEN_B = 2'd0,
        MEM_LEN_H = 2'd1,
        MEM_LEN_W = 2'd2
    } memLen_t;

    typedef enum logic [2:0] {
        MMU_EXCEPTION_NONE        = 3'd0,
        MMU_EXCEPTION_TLB_MISS    = 3'd1,
        MMU_EXCEPTION_TLB_INVALID = 3'd2,
        MMU_EXCEPTION_TLB_MOD     = 3'd3,
        MMU_EXCEPTION_ADDR_ERR    = 3'd4
    } mmuException_t;

    localparam int c_MMU_EXC_W      = $bits(mmuException_t);
    localparam int c_FETCHQ_ENTRY_W = 64 + c_MMU_EXC_W;
    localparam int c_ENTRY_INS_LSB  = 0;
    localparam int c_ENTRY_PC_LSB   = 32;
    localparam int c_ENTRY_EXC_LSB  = 64;

    function automatic logic [c_FETCHQ_ENTRY_W-1:0] packEntry(
        input logic [31:0]   ins,
        input logic [31:0]   pc,
        input mmuException_t exc
    );
        return {exc, pc, ins};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetchq_store.sv
`default_nettype none
// ============================================================================
// Module : fetchq_store
// Brief  : DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
module fetchq_store #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 67
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    // Contents are unreset; the owner tracks validity through its occupancy count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    assign rdData = r_mem[rdAddr];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_prefetch_queue
// Brief  : Run-ahead instruction fetch queue with redirect flush and fault tags.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       clk,
    input  logic                       res,
    output logic [31:0]                db_addr,
    output memAccess_t                 db_accessType,
    output memLen_t                    db_memLen,
    input  logic [31:0]                db_dataIn,
    input  logic                       db_ready,
    input  mmuException_t              mmu_exception,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       q_valid,
    output logic [31:0]                q_ins,
    output logic [31:0]                q_pc,
    output mmuException_t              q_exc,
    input  logic                       q_pop,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [31:0]                 r_fetchPc;
    logic [c_PW-1:0]             r_rdPtr;
    logic [c_PW-1:0]             r_wrPtr;
    logic [c_CW-1:0]             r_count;
    logic                        r_halted;

    logic                        w_req;
    logic                        w_fault;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_valid;
    logic [c_FETCHQ_ENTRY_W-1:0] w_wrData;
    logic [c_FETCHQ_ENTRY_W-1:0] w_rdData;

    assign w_req   = !res && !r_halted && !redirect && (r_count < c_CW'(DEPTH));
    // A fault completes the request on its own; the bus handshake is irrelevant then.
    assign w_fault = w_req && (mmu_exception != MMU_EXCEPTION_NONE);
    assign w_push  = w_req && (db_ready || w_fault);
    assign w_valid = (r_count != '0);
    assign w_pop   = q_pop && w_valid;

    assign w_wrData = w_fault ? packEntry(32'h0, r_fetchPc, mmu_exception)
                              : packEntry(db_dataIn, r_fetchPc, MMU_EXCEPTION_NONE);

    fetchq_store #(
        .DEPTH (DEPTH),
        .WIDTH (c_FETCHQ_ENTRY_W)
    ) u_store (
        .clk    (clk),
        .wrEn   (w_push),
        .wrAddr (r_wrPtr),
        .wrData (w_wrData),
        .rdAddr (r_rdPtr),
        .rdData (w_rdData)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_fetchPc <= RESET_PC;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else if (redirect) begin
            r_fetchPc <= redirect_pc;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (w_fault) begin
                    r_halted <= 1'b1;
                end else begin
                    r_fetchPc <= r_fetchPc + PC_STEP;
                end
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign db_addr       = r_fetchPc;
    assign db_accessType = w_req ? MEM_ACCESS_X : MEM_ACCESS_NONE;
    assign db_memLen     = MEM_LEN_W;

    assign q_valid = w_valid;
    assign q_count = r_count;
    assign q_ins   = w_valid ? w_rdData[c_ENTRY_INS_LSB +: 32] : 32'h0;
    assign q_pc    = w_valid ? w_rdData[c_ENTRY_PC_LSB +: 32] : 32'h0;
    assign q_exc   = w_valid ? mmuException_t'(w_rdData[c_ENTRY_EXC_LSB +: c_MMU_EXC_W])
                             : MMU_EXCEPTION_NONE;

endmodule
`default_nettype wire
